led_breather: RTL and testbench



---
 rtl/led_breather_pkg.sv | 26 ++
 rtl/led_breather_pwm_gen.sv | 37 +++
 rtl/led_breather.sv | 117 +++++++++++
 tb/tb_led_breather.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_breather_pkg.sv
// Shared state encoding and saturating duty arithmetic for the LED breather.
// Pure declarations; no latency or backpressure of its own.
package led_breather_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        PEAK = 2'd2,
        FALL = 2'd3
    } state_t;

    // Operands are widened by one bit so the sum cannot wrap before clamping.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (b > a) ? 32'd0 : (a - b);
    endfunction

endpackage

// File: rtl/led_breather_pwm_gen.sv
// PWM generator: period 2^PWM_BITS-1 clocks, duty shadowed and reloaded only at the wrap.
// Latency: led registered one clock after the compare; new duty visible after the next wrap.
// No backpressure: free-running, duty input sampled once per period.
module led_breather_pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] MAX_D = '1;
    localparam logic [PWM_BITS-1:0] LAST  = MAX_D - 1'b1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_active;
    logic                wrap;

    assign wrap = (pwm_cnt == LAST);

    // Counter never reaches MAX, so duty_active==MAX keeps led constantly on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt     <= '0;
            duty_active <= '0;
            led         <= 1'b0;
        end else begin
            pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
            if (wrap) begin
                duty_active <= duty;
            end
            led <= (pwm_cnt < duty_active);
        end
    end

endmodule

// File: rtl/led_breather.sv
// LED breathing fade: ramps PWM duty up/down by STEP per step_tick with a hold at full brightness.
// Latency: duty/state update on the edge sampling step_tick; led follows after the next PWM wrap.
// No backpressure: step_tick pulses are consumed once per cycle high, ignored in IDLE.
module led_breather #(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                step_tick,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic [1:0]          state,
    output logic                cycle_done
);

    import led_breather_pkg::*;

    localparam int                  MAX   = (2 ** PWM_BITS) - 1;
    localparam logic [PWM_BITS-1:0] MAX_D = '1;
    localparam int                  HW    = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_TICKS);

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [HW-1:0]       hold_q, hold_d, hold_inc;
    logic                done_q, done_d;
    logic [PWM_BITS-1:0] duty_up, duty_dn;

    assign duty_up  = PWM_BITS'(sat_add(32'(duty_q), 32'(STEP), 32'(MAX)));
    assign duty_dn  = PWM_BITS'(sat_sub(32'(duty_q), 32'(STEP)));
    assign hold_inc = hold_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                duty_d = '0;
                if (en) begin
                    state_d = RISE;
                end
            end
            RISE: begin
                if (!en) begin
                    // Losing enable mid-rise turns a coincident tick into a fade step.
                    state_d = FALL;
                    if (step_tick) begin
                        duty_d = duty_dn;
                        if (duty_dn == '0) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else if (step_tick) begin
                    duty_d = duty_up;
                    if (duty_up == MAX_D) begin
                        hold_d  = '0;
                        state_d = (HOLD_TICKS == 0) ? FALL : PEAK;
                    end
                end
            end
            PEAK: begin
                if (!en) begin
                    state_d = FALL;
                end else if (step_tick) begin
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_LAST) begin
                        state_d = FALL;
                    end
                end
            end
            FALL: begin
                if (step_tick) begin
                    duty_d = duty_dn;
                    if (duty_dn == '0) begin
                        done_d  = 1'b1;
                        state_d = en ? RISE : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    led_breather_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty_q),
        .led   (led)
    );

    assign duty       = duty_q;
    assign state      = state_q;
    assign cycle_done = done_q;

endmodule

// File: tb/tb_led_breather.sv
// Bench for led_breather: three instances (STEP/HOLD variants) share stimulus and are
// compared every cycle against a period-level behavioural model, plus literal expectations.
module tb_led_breather;

    localparam int MAXV = 15;
    localparam int NI   = 3;
    localparam int P_STEP [NI] = '{5, 4, 5};
    localparam int P_HOLD [NI] = '{2, 2, 0};
    localparam int S_IDLE = 0, S_RISE = 1, S_PEAK = 2, S_FALL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic step_tick = 1'b0;

    logic       led_o   [NI];
    logic [3:0] duty_o  [NI];
    logic [1:0] state_o [NI];
    logic       done_o  [NI];

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b1;

    always #5 clk = ~clk;

    led_breather #(.PWM_BITS(4), .STEP(5), .HOLD_TICKS(2)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .step_tick(step_tick),
        .led(led_o[0]), .duty(duty_o[0]), .state(state_o[0]), .cycle_done(done_o[0]));
    led_breather #(.PWM_BITS(4), .STEP(4), .HOLD_TICKS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .step_tick(step_tick),
        .led(led_o[1]), .duty(duty_o[1]), .state(state_o[1]), .cycle_done(done_o[1]));
    led_breather #(.PWM_BITS(4), .STEP(5), .HOLD_TICKS(0)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .step_tick(step_tick),
        .led(led_o[2]), .duty(duty_o[2]), .state(state_o[2]), .cycle_done(done_o[2]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edge count since reset gives the PWM position; the duty seen by a period is
    // whatever the ramp held when the previous period ended.
    int m_st [NI] = '{0, 0, 0};
    int m_d  [NI] = '{0, 0, 0};
    int m_h  [NI] = '{0, 0, 0};
    int m_dn [NI] = '{0, 0, 0};
    int m_led[NI] = '{0, 0, 0};
    int m_pd [NI] = '{0, 0, 0};
    int m_e  [NI] = '{0, 0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_st[i] = S_IDLE; m_d[i] = 0; m_h[i] = 0; m_dn[i] = 0;
                m_led[i] = 0; m_pd[i] = 0; m_e[i] = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                int pos, up, dn;
                pos = m_e[i] % MAXV;
                m_led[i] = (pos < m_pd[i]) ? 1 : 0;
                if (pos == MAXV - 1) m_pd[i] = m_d[i];
                m_e[i]++;
                up = (m_d[i] + P_STEP[i] > MAXV) ? MAXV : m_d[i] + P_STEP[i];
                dn = (m_d[i] - P_STEP[i] < 0) ? 0 : m_d[i] - P_STEP[i];
                m_dn[i] = 0;
                if (m_st[i] == S_IDLE) begin
                    m_d[i] = 0;
                    if (en) m_st[i] = S_RISE;
                end else if (m_st[i] == S_RISE && en) begin
                    if (step_tick) begin
                        m_d[i] = up;
                        if (up == MAXV) begin
                            m_h[i] = 0;
                            m_st[i] = (P_HOLD[i] == 0) ? S_FALL : S_PEAK;
                        end
                    end
                end else if (m_st[i] == S_PEAK) begin
                    if (!en) m_st[i] = S_FALL;
                    else if (step_tick) begin
                        m_h[i]++;
                        if (m_h[i] == P_HOLD[i]) m_st[i] = S_FALL;
                    end
                end else begin
                    // FALL, or RISE with enable dropped: both behave as a fade step.
                    m_st[i] = S_FALL;
                    if (step_tick) begin
                        m_d[i] = dn;
                        if (dn == 0) begin
                            m_dn[i] = 1;
                            m_st[i] = en ? S_RISE : S_IDLE;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("led[%0d]", i), led_o[i], m_led[i]);
                chk($sformatf("duty[%0d]", i), duty_o[i], m_d[i]);
                chk($sformatf("state[%0d]", i), state_o[i], m_st[i]);
                chk($sformatf("cycle_done[%0d]", i), done_o[i], m_dn[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1 step_tick = 1'b1;
        @(posedge clk); #1 step_tick = 1'b0;
    endtask

    task automatic expect_dut(input string name, input int i, input int d, input int st, input int dn);
        chk({name, "_duty"}, duty_o[i], d);
        chk({name, "_state"}, state_o[i], st);
        chk({name, "_done"}, done_o[i], dn);
    endtask

    initial begin
        int hi;
        repeat (4) begin
            @(posedge clk); #1;
            en = 1'($urandom_range(0, 1));
            step_tick = 1'($urandom_range(0, 1));
            #2;
            for (int i = 0; i < NI; i++) begin
                chk("rst_led", led_o[i], 0);
                expect_dut("rst", i, 0, S_IDLE, 0);
            end
        end
        @(negedge clk); en = 1'b0; step_tick = 1'b0;
        #2 rst_n = 1'b1;

        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 expect_dut("en_rise", 0, 0, S_RISE, 0);

        tick(); expect_dut("t1a", 0, 5, S_RISE, 0);  chk("t1b", duty_o[1], 4);
        tick(); expect_dut("t2a", 0, 10, S_RISE, 0); chk("t2b", duty_o[1], 8);
        tick(); expect_dut("t3a", 0, 15, S_PEAK, 0); chk("t3b", duty_o[1], 12);
        expect_dut("t3c_hold0", 2, 15, S_FALL, 0);
        tick(); expect_dut("t4a", 0, 15, S_PEAK, 0); expect_dut("t4b", 1, 15, S_PEAK, 0);
        expect_dut("t4c", 2, 10, S_FALL, 0);
        tick(); expect_dut("t5a", 0, 15, S_FALL, 0);
        tick(); expect_dut("t6a", 0, 10, S_FALL, 0); expect_dut("t6b", 1, 15, S_FALL, 0);
        tick(); expect_dut("t7a", 0, 5, S_FALL, 0);  chk("t7b", duty_o[1], 11);
        tick(); expect_dut("t8a", 0, 0, S_RISE, 1);  chk("t8b", duty_o[1], 7);
        @(posedge clk); #1 chk("done_one_cycle", done_o[0], 0);
        tick(); chk("t9a", duty_o[0], 5); chk("t9b", duty_o[1], 3);
        tick(); expect_dut("t10a", 0, 10, S_RISE, 0); expect_dut("t10b", 1, 0, S_RISE, 1);

        // en drops together with a tick while rising at duty 10
        @(posedge clk); #1 en = 1'b0; step_tick = 1'b1;
        @(posedge clk); #1 step_tick = 1'b0;
        expect_dut("stop_a", 0, 5, S_FALL, 0);
        expect_dut("stop_c", 2, 5, S_FALL, 0);

        repeat (32) @(posedge clk);
        hi = 0;
        repeat (15) begin @(negedge clk); hi += int'(led_o[0]); end
        chk("pwm_duty5_a", hi, 5);
        hi = 0;
        repeat (15) begin @(negedge clk); hi += int'(led_o[2]); end
        chk("pwm_duty5_c", hi, 5);

        tick(); expect_dut("stop_end_a", 0, 0, S_IDLE, 1);
        expect_dut("stop_end_c", 2, 0, S_IDLE, 1);
        tick(); tick();
        expect_dut("idle_ignore_a", 0, 0, S_IDLE, 0);
        expect_dut("idle_ignore_b", 1, 0, S_IDLE, 0);

        @(posedge clk); #1 en = 1'b1;
        tick(); tick(); tick();
        expect_dut("peak_again", 0, 15, S_PEAK, 0);
        repeat (35) @(posedge clk);
        #2 chk("led_full_on", led_o[0], 1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) chk("async_rst_led", led_o[i], 0);
        chk("async_rst_state", state_o[0], S_IDLE);
        chk("async_rst_duty", duty_o[0], 0);
        @(negedge clk); en = 1'b0;
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk); #1 cmp_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
